// File: rtl/bullcow_pkg.sv
// rtl/bullcow_pkg.sv - Bulls & Cows shared types: game state codes, display glyphs, glyph-to-segment map.
package bullcow_pkg;

  typedef enum logic [2:0] {
    J1_SETUP = 3'b000,
    J2_SETUP = 3'b001,
    J1_GUESS = 3'b010,
    J2_GUESS = 3'b011,
    END_GAME = 3'b111
  } state_t;

  typedef enum logic [1:0] {
    MODE_PROMPT,
    MODE_RESULT,
    MODE_SCORE,
    MODE_ERROR
  } mode_t;

  typedef enum logic [4:0] {
    HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7,
    HEX8, HEX9, HEXA, HEXB, HEXC, HEXD, HEXE, HEXF,
    GLY_J, GLY_B, GLY_C, GLY_S, GLY_DASH, GLY_BLANK
  } glyph_t;

  function automatic glyph_t hex_glyph(input logic [3:0] nib);
    return glyph_t'({1'b0, nib});
  endfunction

  // Active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] glyph_seg(input glyph_t g);
    logic [6:0] s;
    case (g)
      HEX0:      s = 7'h40;
      HEX1:      s = 7'h79;
      HEX2:      s = 7'h24;
      HEX3:      s = 7'h30;
      HEX4:      s = 7'h19;
      HEX5:      s = 7'h12;
      HEX6:      s = 7'h02;
      HEX7:      s = 7'h78;
      HEX8:      s = 7'h00;
      HEX9:      s = 7'h10;
      HEXA:      s = 7'h08;
      HEXB:      s = 7'h03;
      HEXC:      s = 7'h46;
      HEXD:      s = 7'h21;
      HEXE:      s = 7'h06;
      HEXF:      s = 7'h0E;
      GLY_J:     s = 7'h61;
      GLY_B:     s = 7'h03;
      GLY_C:     s = 7'h46;
      GLY_S:     s = 7'h12;
      GLY_DASH:  s = 7'h3F;
      default:   s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 converter, 8-bit binary to 3-digit BCD.
// One load cycle then eight shift cycles; done pulses once with the result held on bcd_o.
module bin2bcd_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [11:0] bcd_o
);

  typedef enum logic {ST_IDLE, ST_SHIFT} conv_state_t;

  conv_state_t state_q, state_d;
  logic [18:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [11:0] bcd_q, bcd_d;
  logic [18:0] adj;
  logic [19:0] shifted;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    // Hundreds never exceeds 2 for an 8-bit input, so only units and tens need the add-3.
    adj = sr_q;
    if (adj[11:8] >= 4'd5) adj[11:8] = adj[11:8] + 4'd3;
    if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
    shifted = {adj, 1'b0};
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sr_d    = {11'd0, bin_i};
          cnt_d   = 3'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = shifted[18:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          bcd_d   = shifted[19:8];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q == ST_SHIFT);
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/bullcow_display.sv
// rtl/bullcow_display.sv - Bulls & Cows display back end: mode formatting, digit scan, blink, score BCD.
// All of an/seg/dp are registered; the mode is decoded combinationally each cycle.
module bullcow_display
  import bullcow_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  game_state,
  input  logic [15:0] SW,
  input  logic        J1_guess_confirmed,
  input  logic        J2_guess_confirmed,
  input  logic [2:0]  J1_bull_count,
  input  logic [2:0]  J1_cow_count,
  input  logic [2:0]  J2_bull_count,
  input  logic [2:0]  J2_cow_count,
  input  logic [7:0]  J1_points,
  input  logic [7:0]  J2_points,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               load_sel_q, load_sel_d;
  logic               conv_sel_q, conv_sel_d;
  logic [11:0]        j1_bcd_q, j1_bcd_d;
  logic [11:0]        j2_bcd_q, j2_bcd_d;
  logic [7:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  mode_t       mode;
  glyph_t      glyph;
  logic [3:0]  sw_nib;
  logic [2:0]  bulls, cows;
  logic        conv_start, conv_busy, conv_done;
  logic [7:0]  conv_bin;
  logic [11:0] conv_bcd;

  bin2bcd_seq u_bcd (
    .clock   (clock),
    .reset   (reset),
    .start_i (conv_start),
    .bin_i   (conv_bin),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      load_sel_q  <= 1'b0;
      conv_sel_q  <= 1'b0;
      j1_bcd_q    <= '0;
      j2_bcd_q    <= '0;
      an_q        <= 8'hFF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      load_sel_q  <= load_sel_d;
      conv_sel_q  <= conv_sel_d;
      j1_bcd_q    <= j1_bcd_d;
      j2_bcd_q    <= j2_bcd_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  always_comb begin
    mode = MODE_ERROR;
    case (state_t'(game_state))
      J1_SETUP, J2_SETUP: mode = MODE_PROMPT;
      J1_GUESS: mode = J1_guess_confirmed ? MODE_RESULT : MODE_PROMPT;
      J2_GUESS: mode = J2_guess_confirmed ? MODE_RESULT : MODE_PROMPT;
      END_GAME: mode = MODE_SCORE;
      default:  mode = MODE_ERROR;
    endcase
  end

  // The converter accepts a load whenever idle; the top alternates J1/J2 and tags each
  // in-flight conversion so the result lands in the right register.
  always_comb begin
    conv_start = ~conv_busy;
    conv_bin   = load_sel_q ? J2_points : J1_points;
    load_sel_d = load_sel_q;
    conv_sel_d = conv_sel_q;
    j1_bcd_d   = j1_bcd_q;
    j2_bcd_d   = j2_bcd_q;
    if (conv_done) begin
      if (conv_sel_q) j2_bcd_d = conv_bcd;
      else            j1_bcd_d = conv_bcd;
    end
    if (conv_start) begin
      conv_sel_d = load_sel_q;
      load_sel_d = ~load_sel_q;
    end
  end

  always_comb begin
    scan_cnt_d = (scan_cnt_q == SCAN_MAX) ? '0 : scan_cnt_q + 1'b1;
    idx_d      = (scan_cnt_q == SCAN_MAX) ? idx_q + 3'd1 : idx_q;
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (mode == MODE_SCORE) begin
      blink_cnt_d = (blink_cnt_q == BLINK_MAX) ? '0 : blink_cnt_q + 1'b1;
      blink_d     = (blink_cnt_q == BLINK_MAX) ? ~blink_q : blink_q;
    end
  end

  always_comb begin
    glyph = GLY_BLANK;
    case (idx_q[1:0])
      2'd0:    sw_nib = SW[3:0];
      2'd1:    sw_nib = SW[7:4];
      2'd2:    sw_nib = SW[11:8];
      default: sw_nib = SW[15:12];
    endcase
    bulls = game_state[0] ? J2_bull_count : J1_bull_count;
    cows  = game_state[0] ? J2_cow_count  : J1_cow_count;
    case (mode)
      MODE_PROMPT, MODE_RESULT: begin
        if (!idx_q[2]) begin
          glyph = hex_glyph(sw_nib);
        end else if (mode == MODE_PROMPT) begin
          case (idx_q[1:0])
            2'd3:    glyph = GLY_J;
            2'd2:    glyph = game_state[0] ? HEX2 : HEX1;
            default: glyph = GLY_BLANK;
          endcase
        end else begin
          case (idx_q[1:0])
            2'd3:    glyph = GLY_B;
            2'd2:    glyph = hex_glyph({1'b0, bulls});
            2'd1:    glyph = GLY_C;
            default: glyph = hex_glyph({1'b0, cows});
          endcase
        end
      end
      MODE_SCORE: begin
        case (idx_q)
          3'd7:    glyph = HEX1;
          3'd6:    glyph = hex_glyph(j1_bcd_q[11:8]);
          3'd5:    glyph = hex_glyph(j1_bcd_q[7:4]);
          3'd4:    glyph = hex_glyph(j1_bcd_q[3:0]);
          3'd3:    glyph = HEX2;
          3'd2:    glyph = hex_glyph(j2_bcd_q[11:8]);
          3'd1:    glyph = hex_glyph(j2_bcd_q[7:4]);
          default: glyph = hex_glyph(j2_bcd_q[3:0]);
        endcase
      end
      default: glyph = GLY_DASH;
    endcase
    an_d  = (mode == MODE_SCORE && blink_q) ? 8'hFF : ~(8'd1 << idx_q);
    seg_d = glyph_seg(glyph);
    dp_d  = !(mode == MODE_SCORE && idx_q == 3'd4);
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
